// File: rtl/wbvio_sequencer.sv
// Command sequencer driving the VIO-to-WISHBONE bridge go/lock/done/err handshake.
// Define WBVIO_SEQ_RSP_FIFO_EN for a 4-entry response FIFO; default is a single holding register.
module wbvio_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned ADR_W          = 20
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [ADR_W-1:0] cmd_adr_i,
  input  logic [31:0]      cmd_dat_i,
  input  logic             cmd_lock_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_dat_o,
  output logic             rsp_err_o,
  output logic             rsp_tmo_o,
  output logic [31:0]      wbvio_dat_o,
  output logic [ADR_W-1:0] wbvio_adr_o,
  output logic             wbvio_we_o,
  output logic             wbvio_go_o,
  output logic             wbvio_lock_o,
  input  logic [31:0]      wbvio_dat_i,
  input  logic             wbvio_done_i,
  input  logic             wbvio_err_i
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_REARM} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [31:0]        dat_q, dat_d;
  logic               go_q, go_d;
  logic               lock_q, lock_d;
  logic               keep_lock_q, keep_lock_d;

  logic               slot_free;
  logic               cmd_acc;
  logic               pop;
  logic               push;
  logic [31:0]        push_dat;
  logic               push_err;
  logic               push_tmo;
  logic               tmo_hit;

  assign cmd_ready_o  = rst_n_i && (state_q == S_IDLE) && slot_free;
  assign cmd_acc      = cmd_valid_i && cmd_ready_o;
  assign pop          = rsp_valid_o && rsp_ready_i;
  assign tmo_hit      = !wbvio_done_i && !wbvio_err_i && (cnt_q == TMO_LAST);

  assign wbvio_we_o   = we_q;
  assign wbvio_adr_o  = adr_q;
  assign wbvio_dat_o  = dat_q;
  assign wbvio_go_o   = go_q;
  assign wbvio_lock_o = lock_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    go_d        = go_q;
    lock_d      = lock_q;
    keep_lock_d = keep_lock_q;
    push        = 1'b0;
    push_dat    = 32'd0;
    push_err    = 1'b0;
    push_tmo    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          we_d        = cmd_we_i;
          adr_d       = cmd_adr_i;
          dat_d       = cmd_dat_i;
          keep_lock_d = cmd_lock_i;
          go_d        = 1'b1;
          lock_d      = 1'b1;
          cnt_d       = 16'd0;
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 16'd1;
        if (wbvio_done_i) begin
          push     = 1'b1;
          push_dat = we_q ? 32'd0 : wbvio_dat_i;
        end else if (wbvio_err_i) begin
          push     = 1'b1;
          push_err = 1'b1;
        end else if (tmo_hit) begin
          push     = 1'b1;
          push_tmo = 1'b1;
        end
        if (push) begin
          go_d    = 1'b0;
          lock_d  = keep_lock_q && !tmo_hit;
          cnt_d   = 16'd0;
          state_d = S_REARM;
        end
      end
      S_REARM: begin
        // Wait for the bridge to drop done/err so the next go is a clean rising edge.
        if (!wbvio_done_i && !wbvio_err_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= 32'd0;
      go_q        <= 1'b0;
      lock_q      <= 1'b0;
      keep_lock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      go_q        <= go_d;
      lock_q      <= lock_d;
      keep_lock_q <= keep_lock_d;
    end
  end

`ifdef WBVIO_SEQ_RSP_FIFO_EN
  logic [33:0] fifo_q [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;

  assign slot_free   = (count_q < 3'd4);
  assign rsp_valid_o = (count_q != 3'd0);
  assign {rsp_dat_o, rsp_err_o, rsp_tmo_o} = rsp_valid_o ? fifo_q[rd_ptr_q] : 34'd0;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 3'd1;
    else if (!push && pop) count_d = count_q - 3'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= {push_dat, push_err, push_tmo};
  end
`else
  logic        rsp_valid_q, rsp_valid_d;
  logic [33:0] rsp_q, rsp_d;

  // A same-cycle pop frees the register, so a new command can be accepted.
  assign slot_free   = !rsp_valid_q || rsp_ready_i;
  assign rsp_valid_o = rsp_valid_q;
  assign {rsp_dat_o, rsp_err_o, rsp_tmo_o} = rsp_q;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    if (push) begin
      rsp_valid_d = 1'b1;
      rsp_d       = {push_dat, push_err, push_tmo};
    end else if (pop) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= 34'd0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end
`endif

endmodule

// File: tb/tb_wbvio_sequencer.sv
// Scoreboard bench for wbvio_sequencer with a behavioural bridge model (TIMEOUT_CYCLES=8).
module tb_wbvio_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i, cmd_lock_i;
  logic [19:0] cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_tmo_o;
  logic [31:0] rsp_dat_o;
  logic [31:0] wbvio_dat_o, wbvio_dat_i;
  logic [19:0] wbvio_adr_o;
  logic        wbvio_we_o, wbvio_go_o, wbvio_lock_o, wbvio_done_i, wbvio_err_i;

  wbvio_sequencer #(.TIMEOUT_CYCLES(8), .ADR_W(20)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_lock_i(cmd_lock_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .rsp_tmo_o(rsp_tmo_o),
    .wbvio_dat_o(wbvio_dat_o), .wbvio_adr_o(wbvio_adr_o), .wbvio_we_o(wbvio_we_o),
    .wbvio_go_o(wbvio_go_o), .wbvio_lock_o(wbvio_lock_o), .wbvio_dat_i(wbvio_dat_i),
    .wbvio_done_i(wbvio_done_i), .wbvio_err_i(wbvio_err_i)
  );

`ifdef WBVIO_SEQ_RSP_FIFO_EN
  localparam int PEND = 4;
`else
  localparam int PEND = 1;
`endif

  int total = 0;
  int bad   = 0;
  logic [33:0] exp_q [$];
  int npop = 0, n_acc = 0;
  int go_len = 0, low_len = 0, last_go_len = 0, last_low_len = 0, lock_gap = 0;
  logic go_prev = 1'b0;
  bit sdone = 1'b0;

  // Bridge model knobs: mode 0=done, 1=err, 2=never; lat=go cycle on which it answers.
  int mode = 0, lat = 3, hold = 0;
  logic [31:0] mem [int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  initial begin
    int gcnt = 0;
    int hcnt = 0;
    wbvio_done_i = 1'b0;
    wbvio_err_i  = 1'b0;
    wbvio_dat_i  = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (wbvio_go_o) begin
        gcnt++;
        if (mode != 2 && gcnt == lat) begin
          hcnt = hold;
          if (mode == 1) begin
            wbvio_err_i = 1'b1;
            wbvio_dat_i = 32'h0BAD_0E44;
          end else begin
            wbvio_done_i = 1'b1;
            if (wbvio_we_o) begin
              mem[int'(wbvio_adr_o)] = wbvio_dat_o;
              wbvio_dat_i = 32'hBAD0_BAD0;
            end else begin
              wbvio_dat_i = mem.exists(int'(wbvio_adr_o)) ? mem[int'(wbvio_adr_o)] : 32'd0;
            end
          end
        end
      end else begin
        gcnt = 0;
        if (hcnt > 0) hcnt--;
        else begin
          wbvio_done_i = 1'b0;
          wbvio_err_i  = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each handshake and tracks go high/low run lengths.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (rsp_valid_o && rsp_ready_i) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected: got dat=%h err=%b tmo=%b, none expected",
                   rsp_dat_o, rsp_err_o, rsp_tmo_o);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_dat_o, rsp_err_o, rsp_tmo_o} !== e) begin
            bad++;
            $display("FAIL rsp_%0d: got dat=%h err=%b tmo=%b want dat=%h err=%b tmo=%b",
                     npop, rsp_dat_o, rsp_err_o, rsp_tmo_o, e[33:2], e[1], e[0]);
          end
        end
        npop++;
      end
      if (wbvio_go_o) begin
        if (!go_prev) begin
          last_low_len = low_len;
          go_len = 0;
        end
        go_len++;
        if (!wbvio_lock_o) lock_gap++;
      end else begin
        if (go_prev) begin
          last_go_len = go_len;
          low_len = 0;
        end
        low_len++;
      end
      go_prev = wbvio_go_o;
    end
  end

  task automatic send_cmd(input logic we, input logic [19:0] adr, input logic [31:0] dat,
                          input logic lock, input bit push, input logic [33:0] e);
    bit ok = 1'b0;
    if (push) exp_q.push_back(e);
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_lock_i  = lock;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        @(posedge clk);
        ok = 1'b1;
        n_acc++;
      end
    end
    #1 cmd_valid_i = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL cmd_accept: adr=%h not accepted, required acceptance", adr);
    end
  endtask

  task automatic wait_pops(input int n, input string name);
    int i = 0;
    while (npop < n && i < 400) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk(name, npop, n);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int base;
    mem[32'h10] = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) mem[32'h100 + i] = 32'hA000_0000 + i;
    rst_n_i = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0;
    cmd_dat_i = '0; cmd_lock_i = 1'b0; rsp_ready_i = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_go", wbvio_go_o, 0);
    chk("rst_lock", wbvio_lock_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_cmd_ready", cmd_ready_o, 0);
    rst_n_i = 1'b1;
    #1;
    chk("post_rst_cmd_ready", cmd_ready_o, 1);
    @(posedge clk); #1;

    // Plain read, done on 3rd go cycle
    mode = 0; lat = 3; hold = 0;
    send_cmd(1'b0, 20'h00010, 32'd0, 1'b0, 1'b1, {32'hDEAD_BEEF, 2'b00});
    wait_pops(1, "read_done");
    chk("read_go_len", last_go_len, 3);
    chk("read_lock_off", wbvio_lock_o, 0);

    // Locked write followed by unlocked read of the same word
    send_cmd(1'b1, 20'h00004, 32'h1234_5678, 1'b1, 1'b1, {32'h0, 2'b00});
    wait_pops(2, "wr_done");
    repeat (2) @(posedge clk); #1;
    chk("lock_held_idle", wbvio_lock_o, 1);
    send_cmd(1'b0, 20'h00004, 32'd0, 1'b0, 1'b1, {32'h1234_5678, 2'b00});
    wait_pops(3, "rd_after_wr");
    chk("lock_released", wbvio_lock_o, 0);

    // Bridge holds done 2 cycles after go falls: REARM must stretch the low gap
    lat = 2; hold = 2;
    send_cmd(1'b0, 20'h00100, 32'd0, 1'b0, 1'b1, {32'hA000_0000, 2'b00});
    send_cmd(1'b0, 20'h00101, 32'd0, 1'b0, 1'b1, {32'hA000_0001, 2'b00});
    wait_pops(5, "rearm_pair");
    chk("rearm_low_len", last_low_len, 4);
    hold = 0;

    // Bus error on 2nd go cycle
    mode = 1; lat = 2;
    send_cmd(1'b0, 20'h00020, 32'd0, 1'b0, 1'b1, {32'h0, 2'b10});
    wait_pops(6, "err_done");
    chk("err_go_len", last_go_len, 2);
    chk("err_lock_off", wbvio_lock_o, 0);

    // Timeout with lock requested
    mode = 2;
    send_cmd(1'b0, 20'h00030, 32'd0, 1'b1, 1'b1, {32'h0, 2'b01});
    wait_pops(7, "tmo_done");
    chk("tmo_go_len", last_go_len, 8);
    chk("tmo_lock_off", wbvio_lock_o, 0);

    // Backpressure: five reads queued with the response side stalled
    mode = 0; lat = 2;
    rsp_ready_i = 1'b0;
    base = n_acc;
    sdone = 1'b0;
    fork
      begin
        send_cmd(1'b0, 20'h00100, 32'd0, 1'b0, 1'b1, {32'hA000_0000, 2'b00});
        send_cmd(1'b0, 20'h00101, 32'd0, 1'b0, 1'b1, {32'hA000_0001, 2'b00});
        send_cmd(1'b0, 20'h00102, 32'd0, 1'b0, 1'b1, {32'hA000_0002, 2'b00});
        send_cmd(1'b0, 20'h00103, 32'd0, 1'b0, 1'b1, {32'hA000_0003, 2'b00});
        send_cmd(1'b0, 20'h00104, 32'd0, 1'b0, 1'b1, {32'hA000_0004, 2'b00});
        sdone = 1'b1;
      end
    join_none
    repeat (60) @(posedge clk);
    #1;
    chk("bp_accepted", n_acc - base, PEND);
    chk("bp_cmd_ready", cmd_ready_o, 0);
    chk("bp_rsp_valid", rsp_valid_o, 1);
    chk("bp_head_dat", rsp_dat_o, 32'hA000_0000);
    chk("bp_no_pop", npop, 7);
    rsp_ready_i = 1'b1;
    wait_pops(12, "bp_drain");
    for (int i = 0; i < 400 && !sdone; i++) @(posedge clk);
    #1;
    chk("bp_sender_done", sdone, 1);

    // Reset in the middle of a command that never completes
    mode = 2;
    send_cmd(1'b0, 20'h00040, 32'd0, 1'b1, 1'b0, 34'd0);
    repeat (3) @(posedge clk);
    #1 rst_n_i = 1'b0;
    @(posedge clk);
    #1 rst_n_i = 1'b1;
    #1;
    chk("midrst_go", wbvio_go_o, 0);
    chk("midrst_lock", wbvio_lock_o, 0);
    chk("midrst_rsp_valid", rsp_valid_o, 0);
    chk("midrst_cmd_ready", cmd_ready_o, 1);
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_rsp", npop, 12);
    chk("midrst_go_stays_low", wbvio_go_o, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("lock_with_go", lock_gap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wbvio_sequencer.md
Name: wbvio_sequencer

Overview:
- Command sequencer that sits directly upstream of the VIO-to-WISHBONE bridge.
- Takes queued read/write commands from a host-side valid/ready stream and drives the bridge's level-based handshake: go, lock, done, err.
- Returns one response per command (read data plus status) on a valid/ready stream.
- Times out commands the bus never completes.

Parameters:
- TIMEOUT_CYCLES, 1023: cycles go_o may stay high without done/err before the command is aborted; legal range 2..65535.
- ADR_W, 20: address width; must match the bridge.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  synchronous reset, active-low
- cmd_valid_i  in  1  command available
- cmd_ready_o  out  1  command accepted when valid&&ready
- cmd_we_i  in  1  1=write, 0=read
- cmd_adr_i  in  ADR_W  target address
- cmd_dat_i  in  32  write data
- cmd_lock_i  in  1  keep bus locked after this command
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed when valid&&ready
- rsp_dat_o  out  32  read data; 0 for writes
- rsp_err_o  out  1  bus returned err/rty
- rsp_tmo_o  out  1  command timed out
- wbvio_dat_o  out  32  to bridge write data
- wbvio_adr_o  out  ADR_W  to bridge address
- wbvio_we_o  out  1  to bridge write enable
- wbvio_go_o  out  1  to bridge go (rising edge starts cycle)
- wbvio_lock_o  out  1  to bridge bus lock
- wbvio_dat_i  in  32  from bridge read data
- wbvio_done_i  in  1  from bridge done
- wbvio_err_i  in  1  from bridge err

Behaviour:
- Reset (rst_n_i low at clk edge):
  - All outputs 0; state IDLE; timeout counter 0; response storage emptied.
  - Reset mid-command drops go_o and lock_o on the next edge; no response is produced.
- States: IDLE, BUSY, REARM.
- IDLE:
  - cmd_ready_o = 1 iff response storage has a free slot.
  - On accept, capture we/adr/dat/lock into wbvio_*_o. Next cycle: state BUSY, wbvio_go_o=1, wbvio_lock_o=1.
  - Command outputs are stable for the whole command.
- BUSY:
  - Counter increments each cycle.
  - wbvio_done_i=1 has priority over err: push response {dat=we?0:wbvio_dat_i, err=0, tmo=0}.
  - Else wbvio_err_i=1: push {dat=0, err=1, tmo=0}.
  - Else counter==TIMEOUT_CYCLES-1: push {dat=0, err=0, tmo=1}.
  - Any of these three: go_o=0 next cycle; state REARM; counter cleared.
- REARM:
  - Hold go_o=0 until wbvio_done_i=0 and wbvio_err_i=0, for a minimum of 1 cycle; then IDLE.
  - This guarantees the bridge sees a fresh rising edge for the next command.
- Lock:
  - wbvio_lock_o stays 1 after completion iff the captured lock bit was 1 and the command did not time out.
  - Otherwise it clears in the same cycle go_o clears.
  - Timeout always releases lock.
- Latency: cmd accept -> go_o high is 1 cycle; done_i high -> rsp_valid_o high is 1 cycle; minimum command period is 4 cycles.
- Response storage: rsp_* outputs are registered and hold while rsp_valid_o && !rsp_ready_i.
- Only one command is in flight, and cmd acceptance requires a free slot, so a push never overflows.
- Simultaneous pop and push in the same cycle is allowed; count is unchanged.
- Commands arriving while not IDLE wait (cmd_ready_o=0); no command is dropped.

Optional Feature:
- WBVIO_SEQ_RSP_FIFO_EN
- Defined: response storage is a 4-entry FIFO (2-bit pointers, 3-bit count, wrap at 4). cmd_ready_o in IDLE when count<4. Up to 4 responses may be pending, which lets the host stream commands without draining.
- Undefined: single holding register. cmd_ready_o in IDLE only when rsp_valid_o=0, or when rsp_ready_i=1 in the same cycle.

Test Plan:
- Read: cmd adr=0x00010, we=0; bridge model returns done after 3 cycles with dat=0xDEADBEEF -> go_o high 3 cycles; rsp dat=0xDEADBEEF, err=0, tmo=0; go_o low >=1 cycle before the next go.
- Write then read with lock: cmd1 we=1 adr=0x00004 dat=0x12345678 lock=1; cmd2 read adr=0x00004 lock=0 -> lock_o high from cmd1 start until cmd2 completes; two responses, first dat=0, second dat=0x12345678.
- Error: bridge asserts err on the 2nd cycle of go -> rsp err=1, dat=0; lock_o=0 afterwards if lock=0.
- Timeout: TIMEOUT_CYCLES=8, bridge never responds -> go_o drops after exactly 8 cycles high; rsp tmo=1; lock_o=0 even with lock=1.
- Backpressure: rsp_ready_i=0 and 5 reads queued -> without macro, exactly 1 response pending and cmd_ready_o=0; with macro, 4 pending, 5th command stalls; releasing rsp_ready_i returns responses in order.
- Reset mid-BUSY: rst_n_i low for 1 cycle during go -> next cycle go_o=0, lock_o=0, rsp_valid_o=0, cmd_ready_o=1 after reset.
